// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and width helper for the register file
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

  // valid_count must represent 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_file_rport.sv
// rtl/reg_file_rport.sv - registered read port with range check; write-through forwarding under REG_FILE_BYPASS_EN
module reg_file_rport
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [AW-1:0]                raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic [DEPTH-1:0]             valid,
`ifdef REG_FILE_BYPASS_EN
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         clr,
`endif
  output logic [WIDTH-1:0]             rdata,
  output logic                         rvalid
);

  logic [WIDTH-1:0] nxt_data;
  logic             nxt_valid;
  logic             hit;

  // Addresses at or above DEPTH match no entry and read back as zero/invalid.
  always_comb begin
    nxt_data  = '0;
    nxt_valid = 1'b0;
    hit       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        nxt_data  = mem[i];
        nxt_valid = valid[i];
        hit       = 1'b1;
      end
    end
`ifdef REG_FILE_BYPASS_EN
    if (clr) begin
      nxt_data  = '0;
      nxt_valid = 1'b0;
    end else if (we && hit && (waddr == raddr)) begin
      nxt_data  = wdata;
      nxt_valid = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rdata  <= nxt_data;
      rvalid <= nxt_valid;
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - DEPTH x WIDTH register file, one write and two read ports; REG_FILE_BYPASS_EN enables write-through
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic [CW-1:0]    valid_count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            wsel;
  logic                        wr_new;

  // One-hot write select; out-of-range addresses and clr leave it empty.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && !clr && (waddr == AW'(i))) wsel[i] = 1'b1;
    end
  end

  assign wr_new = |(wsel & ~valid);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mem         <= '0;
      valid       <= '0;
      valid_count <= '0;
    end else if (clr) begin
      mem         <= '0;
      valid       <= '0;
      valid_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel[i]) begin
          mem[i]   <= wdata;
          valid[i] <= 1'b1;
        end
      end
      // Only a fresh entry counts, so the count is bounded by DEPTH.
      if (wr_new) valid_count <= valid_count + CW'(1);
    end
  end

  reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rport_a (
    .clk    (clk),
    .res    (res),
    .raddr  (raddr_a),
    .mem    (mem),
    .valid  (valid),
`ifdef REG_FILE_BYPASS_EN
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .clr    (clr),
`endif
    .rdata  (rdata_a),
    .rvalid (rvalid_a)
  );

  reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rport_b (
    .clk    (clk),
    .res    (res),
    .raddr  (raddr_b),
    .mem    (mem),
    .valid  (valid),
`ifdef REG_FILE_BYPASS_EN
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .clr    (clr),
`endif
    .rdata  (rdata_b),
    .rvalid (rvalid_b)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed check of reg_file (DEPTH 8 and 6) against a reference model
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rd_a8, rd_b8, rd_a6, rd_b6;
  logic        rv_a8, rv_b8, rv_a6, rv_b6;
  logic [3:0]  cnt8;
  logic [2:0]  cnt6;

  int total = 0;
  int bad   = 0;

  logic [31:0] m [2][8];
  bit          v [2][8];
  int          dep [2] = '{8, 6};
  logic [31:0] ea_d [2];
  logic [31:0] eb_d [2];
  bit          ea_v [2];
  bit          eb_v [2];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(32), .DEPTH(8)) u8 (
    .clk(clk), .res(res), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a8), .rdata_b(rd_b8),
    .rvalid_a(rv_a8), .rvalid_b(rv_b8), .valid_count(cnt8)
  );

  reg_file #(.WIDTH(32), .DEPTH(6)) u6 (
    .clk(clk), .res(res), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a6), .rdata_b(rd_b6),
    .rvalid_a(rv_a6), .rvalid_b(rv_b6), .valid_count(cnt6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int count_of(input int k);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[k][i]) n++;
    return n;
  endfunction

  task automatic model_read(input int k, input int a, output logic [31:0] d, output bit vv);
    if (a >= dep[k]) begin
      d = 0; vv = 0;
    end else if (BYP && clr) begin
      d = 0; vv = 0;
    end else if (BYP && we && (int'(waddr) == a)) begin
      d = wdata; vv = 1;
    end else begin
      d = m[k][a]; vv = v[k][a];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m[k][i] = 0;
        v[k][i] = 0;
      end
      ea_d[k] = 0; eb_d[k] = 0; ea_v[k] = 0; eb_v[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":a8"},  rd_a8,         ea_d[0]);
    chk({tag, ":va8"}, 32'(rv_a8),    32'(ea_v[0]));
    chk({tag, ":b8"},  rd_b8,         eb_d[0]);
    chk({tag, ":vb8"}, 32'(rv_b8),    32'(eb_v[0]));
    chk({tag, ":c8"},  32'(cnt8),     32'(count_of(0)));
    chk({tag, ":a6"},  rd_a6,         ea_d[1]);
    chk({tag, ":va6"}, 32'(rv_a6),    32'(ea_v[1]));
    chk({tag, ":b6"},  rd_b6,         eb_d[1]);
    chk({tag, ":vb6"}, 32'(rv_b6),    32'(eb_v[1]));
    chk({tag, ":c6"},  32'(cnt6),     32'(count_of(1)));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (res) begin
      for (int k = 0; k < 2; k++) begin
        model_read(k, int'(raddr_a), ea_d[k], ea_v[k]);
        model_read(k, int'(raddr_b), eb_d[k], eb_v[k]);
        if (clr) begin
          for (int i = 0; i < 8; i++) begin
            m[k][i] = 0;
            v[k][i] = 0;
          end
        end else if (we && int'(waddr) < dep[k]) begin
          m[k][waddr] = wdata;
          v[k][waddr] = 1;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] d,
                    input logic [2:0] ra, input logic [2:0] rb);
    we = 1; clr = 0; waddr = a; wdata = d; raddr_a = ra; raddr_b = rb;
    tick(tag);
    we = 0;
  endtask

  task automatic rd(input string tag, input logic [2:0] ra, input logic [2:0] rb);
    we = 0; clr = 0; raddr_a = ra; raddr_b = rb;
    tick(tag);
  endtask

  initial begin
    model_reset();
    #1 res = 0;
    #1;
    check_all("reset");
    #1 res = 1;

    wr("w3", 3'd3, 32'hDEADBEEF, 3'd0, 3'd0);
    wr("w5", 3'd5, 32'h12345678, 3'd0, 3'd0);
    rd("r35", 3'd3, 3'd5);
    chk("basic_a", rd_a8, 32'hDEADBEEF);
    chk("basic_b", rd_b8, 32'h12345678);
    chk("basic_cnt", 32'(cnt8), 32'd2);

    clr = 1; tick("clr0"); clr = 0;
    wr("ow1", 3'd3, 32'h11111111, 3'd3, 3'd3);
    wr("ow2", 3'd3, 32'h22222222, 3'd3, 3'd3);
    chk("ow_cnt", 32'(cnt8), 32'd1);

    for (int i = 0; i < 8; i++) wr("fill", 3'(i), 32'hF000_0000 + 32'(i), 3'(i), 3'(7 - i));
    chk("fill_cnt", 32'(cnt8), 32'd8);
    for (int i = 0; i < 8; i++) wr("refill", 3'(i), $urandom, 3'(i), 3'(i));
    chk("refill_cnt", 32'(cnt8), 32'd8);
    chk("fill6_cnt", 32'(cnt6), 32'd6);

    wr("coll_pre", 3'd2, 32'h00000001, 3'd0, 3'd1);
    wr("coll", 3'd2, 32'hA5A5A5A5, 3'd2, 3'd2);
    chk("coll_a", rd_a8, BYP ? 32'hA5A5A5A5 : 32'h00000001);
    rd("coll_next", 3'd2, 3'd2);
    chk("coll_next_a", rd_a8, 32'hA5A5A5A5);

    we = 1; clr = 1; waddr = 3'd4; wdata = 32'hCAFEF00D; raddr_a = 3'd4; raddr_b = 3'd2;
    tick("clr_we");
    we = 0; clr = 0;
    chk("clr_cnt", 32'(cnt8), 32'd0);
    rd("clr_rd", 3'd4, 3'd4);
    chk("clr_rd_v", 32'(rv_a8), 32'd0);
    chk("clr_rd_d", rd_a8, 32'd0);

    wr("w1_6", 3'd1, 32'h0BADC0DE, 3'd0, 3'd0);
    wr("w7_6", 3'd7, 32'h77777777, 3'd7, 3'd6);
    chk("oob_cnt6", 32'(cnt6), 32'd1);
    rd("oob_rd", 3'd6, 3'd7);
    chk("oob_rd6", rd_a6, 32'd0);
    chk("oob_rv6", 32'(rv_a6), 32'd0);

    for (int n = 0; n < 400; n++) begin
      we      = 1'($urandom_range(0, 1));
      clr     = ($urandom_range(0, 19) == 0);
      waddr   = 3'($urandom_range(0, 7));
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_b = 3'($urandom_range(0, 7));
      wdata   = $urandom;
      tick("rand");
    end
    we = 0; clr = 0;

    for (int i = 0; i < 4; i++) wr("pre_rst", 3'(i), $urandom, 3'(i), 3'(i));
    #2 res = 0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 res = 1;
    for (int i = 0; i < 8; i++) begin
      rd("post_rst", 3'(i), 3'(7 - i));
      chk("post_rst_v", 32'(rv_a8), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised register file: the next generation of the single 32-bit D flip-flop register. DEPTH words of WIDTH bits each, with one synchronous write port, two registered read ports, per-entry valid tracking, a synchronous clear-all and a live count of valid entries. It serves as the general-purpose register bank for datapath blocks that previously instantiated discrete 32-bit registers.

## Interface
Parameters:
- WIDTH, 32, data width of each entry
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; not overridden)
- CW, $clog2(DEPTH+1), width of valid_count (derived)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- res  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- clr  in  1  synchronous clear-all
- raddr_a  in  AW  read address, port A
- raddr_b  in  AW  read address, port B
- rdata_a  out  WIDTH  registered read data, port A
- rdata_b  out  WIDTH  registered read data, port B
- rvalid_a  out  1  valid bit of the entry read on port A
- rvalid_b  out  1  valid bit of the entry read on port B
- valid_count  out  CW  number of entries currently valid

## Operation
- Reset (res=0, asynchronous): every entry cleared to 0, all valid bits 0, rdata_a/rdata_b = 0, rvalid_a/rvalid_b = 0, valid_count = 0. Held while res=0; normal operation resumes on the first rising edge after res rises.
- Write: at an edge with we=1, clr=0 and waddr<DEPTH, mem[waddr] ← wdata and valid[waddr] ← 1.
- valid_count: +1 when the write targets a previously invalid entry; unchanged on overwrite of a valid entry; never exceeds DEPTH.
- Clear: at an edge with clr=1, all entries ← 0, all valid ← 0, valid_count ← 0. clr has priority: a simultaneous write is dropped.
- Read: at every edge, each port captures mem[raddr] and valid[raddr] into rdata/rvalid. Ports are independent; equal addresses on A and B are legal and both return the same word.
- Out-of-range address (≥DEPTH): writes ignored with no count change; reads return rdata=0 and rvalid=0.
- Reads never modify state.

## Timing
- Write latency: data is stored at edge N and becomes readable by a read sampled at edge N+1, appearing at the output after edge N+1.
- Read latency: 1 cycle (address at edge N → rdata/rvalid valid after edge N).
- Same-edge write and read of the same address: behaviour selected by the configuration macro below.
- Same-edge clr and read: without bypass, the read returns pre-clear contents; with bypass, it returns rdata=0 and rvalid=0.
- Asynchronous reset asserted mid-cycle clears all outputs immediately, without waiting for a clock edge.

## Configuration
- REG_FILE_BYPASS_EN defined: write-through forwarding. A read port whose raddr equals waddr at an edge with we=1, clr=0 captures wdata with rvalid=1. clr in the same edge forces that port to 0 and invalid.
- REG_FILE_BYPASS_EN undefined: no forwarding. A same-edge read returns the old entry contents and old valid bit.

## Structure
- A shared package reg_file_pkg holds the default WIDTH/DEPTH constants and a helper function for the count-width calculation.
- The read port is a natural sub-module, reg_file_rport: address decode, range check, optional bypass mux and output register. It is instantiated twice.
- Storage, valid bits and the counter stay in the top module.

## Test plan
- Reset: drive res=0 mid-cycle after writes → all rdata/rvalid/valid_count go to 0 immediately; reads of every address after release return 0 with rvalid=0.
- Basic write/read: write 0xDEADBEEF to addr 3, then 0x12345678 to addr 5; read A=3, B=5 → 0xDEADBEEF/0x12345678, both rvalid=1, valid_count=2.
- Overwrite and fill: write addr 3 twice → count stays at 1; write all 8 entries → valid_count=8, no further increment on rewrites.
- Same-address collision: write 0xA5A5A5A5 to addr 2 (old value 0x1) while A reads 2 → 0xA5A5A5A5 with REG_FILE_BYPASS_EN, 0x00000001 without; the next cycle returns 0xA5A5A5A5 in both builds.
- Clear priority: clr=1 with we=1 to addr 4 → valid_count=0, the following read of 4 gives 0 with rvalid=0.
- DEPTH=6: write addr 7 → ignored, count unchanged; read addr 6 → rdata=0, rvalid=0.
